// File: rtl/relu_writeback_serializer.sv
// ============================================================================
// relu_writeback_serializer
//   Captures one ReLU output vector and streams it out as BEATS address-tagged
//   beats over a valid/ready channel, counting all-zero elements at capture.
// Revision: 1.0
// ============================================================================
`default_nettype none

module relu_writeback_serializer #(
  parameter int WIDTH      = 16,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 16,
  parameter int SYS_HEIGHT = 1,
  parameter int BEAT_ELEMS = 16,
  parameter int ADDR_W     = 16,
  localparam int N         = ARR_HEIGHT * SYS_HEIGHT * ARR_WIDTH * SYS_WIDTH,
  localparam int BEATS     = N / BEAT_ELEMS,
  localparam int ZC_W      = $clog2(N + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N*WIDTH-1:0]            in_data,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BEAT_ELEMS*WIDTH-1:0]   out_data,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_last,
  output logic                          done,
  output logic [ZC_W-1:0]               zero_count
);

  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BITS = BEAT_ELEMS * WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [N*WIDTH-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ZC_W-1:0]       zc_q, zc_d;
  logic                  done_q, done_d;
  logic [ZC_W-1:0]       zc_calc;
  logic                  last_beat;

  always_comb begin
    zc_calc = '0;
    for (int i = 0; i < N; i++) begin
      if (in_data[i*WIDTH +: WIDTH] == '0) begin
        zc_calc = zc_calc + ZC_W'(1);
      end
    end
  end

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    addr_d  = addr_q;
    zc_d    = zc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          addr_d  = base_addr;
          beat_d  = '0;
          zc_d    = zc_calc;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      zc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      zc_q    <= zc_d;
      done_q  <= done_d;
    end
  end

  // Beat payload is selected straight from the captured register, so input
  // changes after capture never reach the output.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == SEND);
  assign out_last   = (state_q == SEND) && last_beat;
  assign out_data   = data_q[int'(beat_q)*BEAT_BITS +: BEAT_BITS];
  assign out_addr   = addr_q + ADDR_W'(beat_q);
  assign done       = done_q;
  assign zero_count = zc_q;

endmodule

`default_nettype wire

// File: doc/relu_writeback_serializer.md
RELU_WRITEBACK_SERIALIZER -- requirements
Module: relu_writeback_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, element width in bits.
REQ-002 The block SHALL have parameter ARR_WIDTH, default 4, PEs per array row.
REQ-003 The block SHALL have parameter ARR_HEIGHT, default 4, PEs per array column.
REQ-004 The block SHALL have parameter SYS_WIDTH, default 16, arrays horizontally.
REQ-005 The block SHALL have parameter SYS_HEIGHT, default 1, arrays vertically.
REQ-006 The block SHALL have parameter BEAT_ELEMS, default 16, elements per output beat.
REQ-007 The block SHALL have parameter ADDR_W, default 16, output address width.
REQ-008 Derived: N = ARR_HEIGHT*SYS_HEIGHT*ARR_WIDTH*SYS_WIDTH (256); BEATS = N/BEAT_ELEMS (16); ZC_W = clog2(N+1); N SHALL be a multiple of BEAT_ELEMS.
REQ-009 clk  input  1  single clock, rising edge.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 in_valid  input  1  activation vector from ReLU stage is valid.
REQ-012 in_ready  output  1  block can accept a vector.
REQ-013 in_data  input  N*WIDTH  ReLU output vector, element i at bits [WIDTH*(i+1)-1 : WIDTH*i].
REQ-014 base_addr  input  ADDR_W  destination address of beat 0, sampled with in_data.
REQ-015 out_valid  output  1  out_data/out_addr valid.
REQ-016 out_ready  input  1  downstream buffer accepts beat.
REQ-017 out_data  output  BEAT_ELEMS*WIDTH  current beat.
REQ-018 out_addr  output  ADDR_W  address of current beat.
REQ-019 out_last  output  1  current beat is beat BEATS-1.
REQ-020 done  output  1  one-cycle pulse after final beat accepted.
REQ-021 zero_count  output  ZC_W  number of all-zero elements in last captured vector.

Function
REQ-022 States: IDLE, SEND; in_ready SHALL be 1 exactly in IDLE.
REQ-023 IDLE: on in_valid&in_ready the block SHALL register in_data, base_addr, reset beat counter to 0, enter SEND.
REQ-024 zero_count SHALL be updated at capture with the count of elements equal to 0, held until the next capture.
REQ-025 out_valid SHALL assert the cycle after capture (latency 1) and remain 1 throughout SEND.
REQ-026 out_data SHALL equal captured elements [beat*BEAT_ELEMS .. beat*BEAT_ELEMS+BEAT_ELEMS-1], lowest element in lowest bits.
REQ-027 out_addr SHALL equal (base_addr + beat) mod 2^ADDR_W; wrap-around is silent.
REQ-028 out_data, out_addr, out_last SHALL hold stable while out_valid&!out_ready.
REQ-029 On out_valid&out_ready with beat<BEATS-1 the beat counter SHALL increment.
REQ-030 On out_valid&out_ready with beat==BEATS-1 the block SHALL enter IDLE and pulse done for the next cycle only.
REQ-031 No overlap: in_valid during SEND SHALL be ignored (in_ready=0); a new vector is accepted no earlier than the cycle done is high.
REQ-032 in_data changes while out_valid is high SHALL NOT affect out_data.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, beat=0, in_ready=1 (after release), out_valid=0, out_last=0, done=0, zero_count=0, out_data=0, out_addr=0.
REQ-034 Reset mid-SEND SHALL abandon the vector; no done pulse SHALL be produced for it.

Verification
REQ-035 Capture vector element i = i, base_addr=0x0100, out_ready=1 -> 16 consecutive beats, addr 0x0100..0x010F, beat k holds elements 16k..16k+15, out_last on beat 15, done one cycle later, zero_count=1.
REQ-036 out_ready toggled pseudo-randomly -> beats stable while stalled, no beat lost or duplicated, same sequence as REQ-035.
REQ-037 base_addr=0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
REQ-038 All-zero vector -> zero_count=256, all beats 0; in_valid held high during SEND -> second vector accepted only after done, no corruption of first.
REQ-039 rst_n asserted after beat 5 accepted -> out_valid=0 immediately, no done, next vector restarts at beat 0 with correct data.
